alu_share_arbiter: RTL and testbench

//  Shares one ALU instance between NUM_REQ requesters (e.g. address-gen, branch-compare, debug).

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu.sv | 33 +++
 rtl/alu_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the shared-ALU arbiter
package alu_pkg;

  // ALU select codes; any unlisted code falls back to add
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_SLL = 4'b0010,
    ALU_XOR = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_OR  = 4'b1000,
    ALU_AND = 4'b1001
  } alu_op_e;

  localparam alu_op_e ALU_DEFAULT_OP = ALU_ADD;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU shared by the arbiter's requesters
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [3:0]        select_op,
  output logic [DATA_W-1:0] result_out
);

  // Shift amounts are the whole of operand B, so anything >= DATA_W clears the result
  localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

  logic shift_oob;
  assign shift_oob = (operand_b >= SHIFT_LIMIT);

  // Operation decode; unknown selects compute add with no error indication
  always_comb begin
    result_out = operand_a + operand_b;
    case (select_op)
      ALU_SUB: result_out = operand_a - operand_b;
      ALU_SLL: result_out = shift_oob ? '0 : (operand_a << operand_b);
      ALU_XOR: result_out = operand_a ^ operand_b;
      ALU_SRL: result_out = shift_oob ? '0 : (operand_a >> operand_b);
      ALU_OR:  result_out = operand_a | operand_b;
      ALU_AND: result_out = operand_a & operand_b;
      default: result_out = operand_a + operand_b;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between NUM_REQ requesters
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_b,
  input  logic [NUM_REQ*4-1:0]      req_sel,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  // Lowest index above ptr wins; otherwise wrap to the lowest valid index at or below ptr.
  // Result is {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic            hi_found;
    logic            lo_found;
    logic [ID_W-1:0] hi_win;
    logic [ID_W-1:0] lo_win;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        if (ID_W'(i) > ptr) begin
          hi_found = 1'b1;
          hi_win   = ID_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_win   = ID_W'(i);
        end
      end
    end
    if (hi_found) return {1'b1, hi_win};
    return {lo_found, lo_win};
  endfunction

  arb_state_e        state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [3:0]        sel_q;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_valid_q;
  logic              busy_q;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              grant;
  logic [DATA_W-1:0] gnt_op_a;
  logic [DATA_W-1:0] gnt_op_b;
  logic [3:0]        gnt_sel;
  logic [DATA_W-1:0] alu_result;

  assign {pick_found, pick_idx} = rr_pick(req_valid, rr_ptr_q);
  assign grant = !rst && (state_q == IDLE) && pick_found;

  // One-hot accept toward the winner, only while idle and out of reset
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (pick_idx == ID_W'(i))) req_ready[i] = 1'b1;
    end
  end

  // Select the winning requester's operands for latching
  always_comb begin
    gnt_op_a = '0;
    gnt_op_b = '0;
    gnt_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        gnt_op_a = req_op_a[i*DATA_W +: DATA_W];
        gnt_op_b = req_op_b[i*DATA_W +: DATA_W];
        gnt_sel  = req_sel[i*4 +: 4];
      end
    end
  end

  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .operand_a (op_a_q),
    .operand_b (op_b_q),
    .select_op (sel_q),
    .result_out(alu_result)
  );

  // IDLE -> EXEC -> RESP -> IDLE; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      op_a_q      <= '0;
      op_b_q      <= '0;
      sel_q       <= ALU_DEFAULT_OP;
      id_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            op_a_q   <= gnt_op_a;
            op_b_q   <= gnt_op_b;
            sel_q    <= gnt_sel;
            id_q     <= pick_idx;
            rr_ptr_q <= pick_idx;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_result;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 1;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_op_a;
  logic [NUM_REQ*DATA_W-1:0] req_op_b;
  logic [NUM_REQ*4-1:0]      req_sel;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op_a (req_op_a),
    .req_op_b (req_op_b),
    .req_sel  (req_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel);
    req_op_a[idx*DATA_W +: DATA_W] = a;
    req_op_b[idx*DATA_W +: DATA_W] = b;
    req_sel[idx*4 +: 4]            = sel;
  endtask

  task automatic wait_grant(input string tag, output logic [NUM_REQ-1:0] g);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_ready == '0) check({tag, "_grant_timeout"}, 64'd0, 64'd1);
    g = req_ready;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    #1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rsp_valid) check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] sel, input logic [31:0] exp, input string tag);
    logic [NUM_REQ-1:0] g;
    req_valid = '0;
    set_req(idx, a, b, sel);
    req_valid[idx] = 1'b1;
    wait_grant(tag, g);
    check({tag, "_ready"}, 64'(g), 64'(1) << idx);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(tag);
    check({tag, "_data"}, 64'(rsp_data), 64'(exp));
    check({tag, "_id"}, 64'(rsp_id), 64'(idx));
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [NUM_REQ-1:0] g;

    vecs[0] = '{32'h0000_0000, 32'h0000_0001, 4'b0001, 32'hFFFF_FFFF};
    vecs[1] = '{32'h8000_0000, 32'd31,        4'b0110, 32'h0000_0001};
    vecs[2] = '{32'h0000_0001, 32'd32,        4'b0010, 32'h0000_0000};
    vecs[3] = '{32'd3,         32'd4,         4'b0111, 32'd7};
    vecs[4] = '{32'h0000_F0F0, 32'h0000_FF00, 4'b0101, 32'h0000_0FF0};
    vecs[5] = '{32'h0000_00F0, 32'h0000_000F, 4'b1000, 32'h0000_00FF};
    vecs[6] = '{32'h0000_00F0, 32'h0000_003C, 4'b1001, 32'h0000_0030};
    vecs[7] = '{32'd5,         32'd6,         4'b1111, 32'd11};
    vecs[8] = '{32'hFFFF_FFFF, 32'd40,        4'b0110, 32'h0000_0000};
    vecs[9] = '{32'hFFFF_FFFF, 32'd2,         4'b0000, 32'h0000_0001};

    // reset with every requester asking
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_op_a  = '0;
    req_op_b  = '0;
    req_sel   = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    rst       = 1'b0;
    req_valid = '0;

    // single sub with exact latency
    @(negedge clk);
    set_req(0, 32'd7, 32'd5, 4'b0001);
    req_valid = 2'b01;
    #1;
    check("single_ready_T", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_valid_T1", 64'(rsp_valid), 64'd0);
    check("single_busy_T1", 64'(busy), 64'd1);
    check("single_ready_T1", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    check("single_valid_T2", 64'(rsp_valid), 64'd1);
    check("single_data", 64'(rsp_data), 64'd2);
    check("single_id", 64'(rsp_id), 64'd0);
    @(negedge clk);
    #1;
    check("single_done_valid", 64'(rsp_valid), 64'd0);
    check("single_done_busy", 64'(busy), 64'd0);

    // fairness from a fresh reset: 0,1,0,1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 32'd1, 32'd1, 4'b0000);
    set_req(1, 32'd1, 32'd1, 4'b0000);
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_grant("fair", g);
      check($sformatf("fair_grant%0d", t), 64'(g), (t % 2 == 0) ? 64'd1 : 64'd2);
      @(negedge clk);
      wait_rsp("fair");
      check($sformatf("fair_data%0d", t), 64'(rsp_data), 64'd2);
      check($sformatf("fair_id%0d", t), 64'(rsp_id), 64'(t % 2));
      @(negedge clk);
    end

    // backpressure: req0 sll wins (last grant was 1), req1 waits
    rsp_ready = 1'b0;
    set_req(0, 32'd1, 32'd4, 4'b0010);
    set_req(1, 32'd10, 32'd3, 4'b0000);
    req_valid = 2'b11;
    wait_grant("bp", g);
    check("bp_grant", 64'(g), 64'd1);
    @(negedge clk);
    req_valid = 2'b10;
    wait_rsp("bp");
    check("bp_data", 64'(rsp_data), 64'd16);
    check("bp_id", 64'(rsp_id), 64'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp_hold_valid%0d", c), 64'(rsp_valid), 64'd1);
      check($sformatf("bp_hold_data%0d", c), 64'(rsp_data), 64'd16);
      check($sformatf("bp_hold_ready%0d", c), 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_idle_busy", 64'(busy), 64'd0);
    check("bp_idle_valid", 64'(rsp_valid), 64'd0);
    check("bp_req1_grant", 64'(req_ready), 64'd2);
    @(negedge clk);
    req_valid = '0;
    wait_rsp("bp1");
    check("bp1_data", 64'(rsp_data), 64'd13);
    check("bp1_id", 64'(rsp_id), 64'd1);
    @(negedge clk);

    // ALU edge cases, alternating requesters
    for (int v = 0; v < 10; v++) begin
      do_op(v % 2, vecs[v].a, vecs[v].b, vecs[v].sel, vecs[v].exp, $sformatf("alu%0d", v));
    end

    // reset during EXEC: grant req0 so pointer sits at 0, then abort
    set_req(0, 32'd1, 32'd2, 4'b0000);
    set_req(1, 32'd9, 32'd9, 4'b0000);
    req_valid = 2'b01;
    wait_grant("rx", g);
    check("rx_grant", 64'(g), 64'd1);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("rx_in_exec", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rx_no_rsp%0d", c), 64'(rsp_valid), 64'd0);
      check($sformatf("rx_idle%0d", c), 64'(busy), 64'd0);
      @(negedge clk);
    end
    req_valid = 2'b11;
    #1;
    check("rx_ptr_reset", 64'(req_ready), 64'd1);

    // reset during RESP
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rr_in_resp", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rr_no_rsp%0d", c), 64'(rsp_valid), 64'd0);
      check($sformatf("rr_idle%0d", c), 64'(busy), 64'd0);
      @(negedge clk);
    end
    req_valid = 2'b11;
    #1;
    check("rr_ptr_reset", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = '0;
    wait_rsp("rr");
    check("rr_data", 64'(rsp_data), 64'd3);
    check("rr_id", 64'(rsp_id), 64'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
